huffman_enc_sequencer: RTL
==========================

Name: huffman_enc_sequencer

Overview:
Parametrised successor to the single-channel Huffman controller. It accepts one zigzag-ordered coefficient block per valid/ready handshake, for any of NUM_CH colour components. It computes a per-channel differential DC, run-length scans the AC coefficients (including ZRL and EOB), and drives the external DC/AC table encoder through a fixed-latency request port. It emits a back-pressurable symbol stream to the bit packer.

Parameters:
- COEF_W, 8: signed coefficient width (two's complement).
- NUM_COEF, 64: coefficients per block (≥2).
- NUM_CH, 3: component channels, each with its own DC predictor.
- ENC_LAT, 6: cycles from enc_req to a valid enc_code/enc_len (≥1).
- CODE_W, 16: Huffman code width.
- LEN_W, 8: code-length width.
- RST_INTERVAL, 8: blocks per restart interval (used only with the optional feature).

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- blk_valid, in, 1: input block present.
- blk_ready, out, 1: block can be accepted.
- blk_ch, in, CH_W=max(1,$clog2(NUM_CH)): channel of the block.
- blk_coefs, in, NUM_COEF*COEF_W: coefficient k at [k*COEF_W +: COEF_W].
- dc_clear, in, 1: clear all DC predictors.
- enc_req, out, 1: one-cycle lookup request.
- enc_is_dc, out, 1: request is for the DC table.
- enc_ch, out, CH_W: channel, for table selection.
- enc_run, out, 4: zero run (AC only).
- enc_value, out, COEF_W+1: DC difference or AC value, signed.
- enc_code, in, CODE_W: encoder result code.
- enc_len, in, LEN_W: encoder result length.
- sym_valid, out, 1: symbol available.
- sym_ready, in, 1: downstream accepts the symbol.
- sym_code, out, CODE_W: symbol code.
- sym_len, out, LEN_W: symbol length.
- sym_is_dc, out, 1: symbol is the DC symbol.
- sym_last, out, 1: final symbol of the block.
- busy, out, 1: block in progress.
- rst_marker, out, 1: restart-interval pulse (optional feature).

Behaviour:
- Reset: state IDLE; predictors 0; every output 0 except blk_ready=1.
- IDLE: blk_ready=1. On blk_valid&blk_ready, register coefs/ch and compute last_nz, the highest nonzero AC index, or 0 if every AC coefficient is zero.
- DC difference at accept: diff = coef0 − pred[ch], computed COEF_W+1 bits wide, with no overflow possible. Then pred[ch] ← coef0.
- dc_clear:
  - Clears all predictors in any cycle.
  - In the accept cycle, diff is taken against 0, and pred[ch] is still loaded with coef0.
  - While busy, it affects only later blocks.
- States: IDLE → DC_REQ → WAIT → EMIT → SCAN → AC_REQ → WAIT → EMIT → … → IDLE.
- *_REQ: enc_req=1 for exactly one cycle. enc_is_dc, enc_ch, enc_run and enc_value hold steady from the REQ cycle through the end of WAIT.
- WAIT: count ENC_LAT cycles after the REQ cycle, then latch enc_code/enc_len into sym_code/sym_len.
- EMIT: sym_valid=1, with all sym_* held stable until sym_ready. Transfer occurs on sym_valid&sym_ready; the next state follows in the next cycle. An idle sym_ready stalls the block indefinitely.
- SCAN: index k starts at 1 and examines one coefficient per cycle. A zero run counter starts at 0.
  - k>last_nz: issue EOB (run 0, value 0) with sym_last=1. If last_nz=NUM_COEF−1, no EOB is issued and the last AC symbol carries sym_last=1.
  - coef[k]≠0: issue AC (run, coef[k]), reset run, then k+1.
  - coef[k]=0 with run=15: issue ZRL (run 15, value 0), run←0, then k+1. ZRL is never issued past last_nz.
  - Otherwise: run+1, then k+1.
- After sym_last transfers: IDLE. blk_ready returns one cycle later.
- Minimum latency: accept at T, DC enc_req at T+1, DC sym_valid at T+2+ENC_LAT.
- busy=1 in every state except IDLE.
- Reset mid-block: the block is abandoned, with no partial symbols afterwards.

Optional Feature:
- HUFF_RESTART_EN defined:
  - A block counter increments on each accept.
  - When a block is accepted with count = RST_INTERVAL−1, the counter wraps to 0.
  - On the cycle after that block's sym_last transfers, all predictors clear and rst_marker pulses for 1 cycle.
  - dc_clear also resets the counter.
- Undefined: no counter, and rst_marker is constant 0.

Decomposition:
- Package huff_pkg: state enum, ZRL_RUN=15, EOB run/value constants, and a sym_t struct (code, len, is_dc, last).
- Sub-module huff_last_nz: combinational highest-nonzero-index finder over the AC coefficients, parametrised by NUM_COEF and COEF_W.

Test Plan:
- DC only: ch0, coef0=10, rest 0, pred 0. Expect enc_value=+10 (DC), then EOB with sym_last=1, exactly 2 symbols.
- Predictor: ch0 coef0=10, then ch1 coef0=5, then ch0 coef0=7. Expect DC values 10, 5, −3.
- ZRL: coef[20]=3, others AC 0. Expect DC, ZRL(15), AC(run 3, value 3), EOB. Separately, a block with coef[17] and coef[33] nonzero gives no stray ZRL before EOB.
- Full block: coef[63]=−1. Expect final AC(run 14) after 3 ZRLs to carry sym_last=1, with no EOB.
- Back-pressure: sym_ready low for 20 cycles in EMIT. Expect sym_* stable, no enc_req, and blk_ready=0.
- Restart (with HUFF_RESTART_EN, RST_INTERVAL=2): 3 blocks ch0 coef0=4. Expect DC values 4, 0, 4 and one rst_marker pulse after block 2.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman encode sequencer.
package huff_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDcReq,
    StWait,
    StEmit,
    StScan,
    StAcReq
  } state_e;

  localparam logic [3:0] ZRL_RUN   = 4'd15;
  localparam logic [3:0] EOB_RUN   = 4'd0;
  localparam int         EOB_VALUE = 0;

  // sym_t field widths; the sequencer's CODE_W/LEN_W default to these.
  localparam int unsigned SYM_CODE_W = 16;
  localparam int unsigned SYM_LEN_W  = 8;

  typedef struct packed {
    logic [SYM_CODE_W-1:0] code;
    logic [SYM_LEN_W-1:0]  len;
    logic                  is_dc;
    logic                  last;
  } sym_t;

endpackage

// File: rtl/huff_last_nz.sv
// Combinational finder for the highest nonzero AC coefficient index (0 if all AC are zero).
module huff_last_nz #(
  parameter int unsigned NUM_COEF = 64,
  parameter int unsigned COEF_W   = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_COEF)
) (
  input  logic [(NUM_COEF-1)*COEF_W-1:0] ac_coefs,
  output logic [IDX_W-1:0]               last_nz
);

  // ac_coefs holds coefficients 1..NUM_COEF-1; slot k-1 is coefficient k.
  always_comb begin
    last_nz = '0;
    for (int unsigned k = 1; k < NUM_COEF; k++) begin
      if (ac_coefs[(k-1)*COEF_W +: COEF_W] != '0) last_nz = IDX_W'(k);
    end
  end

endmodule

// File: rtl/huffman_enc_sequencer.sv
// Block-level Huffman symbol sequencer: DC differencing, AC run-length scan, table lookups.
// Optional restart-interval support is enabled by defining HUFF_RESTART_EN.
module huffman_enc_sequencer
  import huff_pkg::*;
#(
  parameter int unsigned COEF_W       = 8,
  parameter int unsigned NUM_COEF     = 64,
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned ENC_LAT      = 6,
  parameter int unsigned CODE_W       = SYM_CODE_W,
  parameter int unsigned LEN_W        = SYM_LEN_W,
  parameter int unsigned RST_INTERVAL = 8,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       blk_valid,
  output logic                       blk_ready,
  input  logic [CH_W-1:0]            blk_ch,
  input  logic [NUM_COEF*COEF_W-1:0] blk_coefs,
  input  logic                       dc_clear,
  output logic                       enc_req,
  output logic                       enc_is_dc,
  output logic [CH_W-1:0]            enc_ch,
  output logic [3:0]                 enc_run,
  output logic [COEF_W:0]            enc_value,
  input  logic [CODE_W-1:0]          enc_code,
  input  logic [LEN_W-1:0]           enc_len,
  output logic                       sym_valid,
  input  logic                       sym_ready,
  output logic [CODE_W-1:0]          sym_code,
  output logic [LEN_W-1:0]           sym_len,
  output logic                       sym_is_dc,
  output logic                       sym_last,
  output logic                       busy,
  output logic                       rst_marker
);

  localparam int unsigned IDX_W = $clog2(NUM_COEF);
  localparam int unsigned K_W   = IDX_W + 1;
  localparam int unsigned LAT_W = $clog2(ENC_LAT + 1);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q;
  logic [IDX_W-1:0]   last_nz_q, last_nz;
  logic [K_W-1:0]     k_q, k_d;
  logic [3:0]         run_q, run_d;
  logic               req_is_dc_q, req_is_dc_d, req_last_q, req_last_d;
  logic [3:0]         req_run_q, req_run_d;
  logic [COEF_W:0]    req_value_q, req_value_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  sym_t               sym_q, sym_d;
  logic [COEF_W-1:0]  ac_q [NUM_COEF-1];
  logic [COEF_W-1:0]  pred_q [NUM_CH];

  logic               accept, ch_ok, pred_clr, restart_clr, last_xfer;
  logic [COEF_W-1:0]  coef0, pred_cur, coef_k;
  logic [COEF_W:0]    dc_diff;
  logic [IDX_W-1:0]   k_idx;

  assign accept   = (state_q == StIdle) & blk_valid;
  assign coef0    = blk_coefs[COEF_W-1:0];
  assign ch_ok    = 32'(blk_ch) < NUM_CH;
  assign pred_clr = dc_clear | restart_clr;
  // A clear landing in the accept cycle already applies to this block's difference.
  assign pred_cur = (pred_clr || !ch_ok) ? '0 : pred_q[blk_ch];
  assign dc_diff  = {coef0[COEF_W-1], coef0} - {pred_cur[COEF_W-1], pred_cur};
  assign k_idx    = IDX_W'(k_q - K_W'(1));
  assign coef_k   = ac_q[k_idx];

  huff_last_nz #(
    .NUM_COEF (NUM_COEF),
    .COEF_W   (COEF_W)
  ) u_last_nz (
    .ac_coefs (blk_coefs[NUM_COEF*COEF_W-1:COEF_W]),
    .last_nz  (last_nz)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      last_nz_q   <= '0;
      k_q         <= K_W'(1);
      run_q       <= '0;
      req_is_dc_q <= 1'b0;
      req_last_q  <= 1'b0;
      req_run_q   <= '0;
      req_value_q <= '0;
      lat_q       <= '0;
      sym_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      run_q       <= run_d;
      req_is_dc_q <= req_is_dc_d;
      req_last_q  <= req_last_d;
      req_run_q   <= req_run_d;
      req_value_q <= req_value_d;
      lat_q       <= lat_d;
      sym_q       <= sym_d;
      if (accept) begin
        ch_q      <= blk_ch;
        last_nz_q <= last_nz;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int unsigned k = 1; k < NUM_COEF; k++) ac_q[k-1] <= blk_coefs[k*COEF_W +: COEF_W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) pred_q[c] <= '0;
    end else begin
      if (pred_clr) begin
        for (int unsigned c = 0; c < NUM_CH; c++) pred_q[c] <= '0;
      end
      if (accept && ch_ok) pred_q[blk_ch] <= coef0;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    run_d       = run_q;
    req_is_dc_d = req_is_dc_q;
    req_last_d  = req_last_q;
    req_run_d   = req_run_q;
    req_value_d = req_value_q;
    lat_d       = lat_q;
    sym_d       = sym_q;
    unique case (state_q)
      StIdle: begin
        if (blk_valid) begin
          state_d     = StDcReq;
          k_d         = K_W'(1);
          run_d       = '0;
          req_is_dc_d = 1'b1;
          req_last_d  = 1'b0;
          req_run_d   = '0;
          req_value_d = dc_diff;
        end
      end
      StDcReq, StAcReq: begin
        lat_d   = LAT_W'(1);
        state_d = StWait;
      end
      StWait: begin
        if (lat_q == LAT_W'(ENC_LAT)) begin
          sym_d.code  = SYM_CODE_W'(enc_code);
          sym_d.len   = SYM_LEN_W'(enc_len);
          sym_d.is_dc = req_is_dc_q;
          sym_d.last  = req_last_q;
          state_d     = StEmit;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      StEmit: begin
        if (sym_ready) state_d = sym_q.last ? StIdle : StScan;
      end
      StScan: begin
        req_is_dc_d = 1'b0;
        req_last_d  = 1'b0;
        if (k_q > {1'b0, last_nz_q}) begin
          req_run_d   = EOB_RUN;
          req_value_d = (COEF_W+1)'(EOB_VALUE);
          req_last_d  = 1'b1;
          state_d     = StAcReq;
        end else if (coef_k != '0) begin
          // A nonzero final coefficient closes the block itself; no EOB follows.
          req_run_d   = run_q;
          req_value_d = {coef_k[COEF_W-1], coef_k};
          req_last_d  = (k_q == K_W'(NUM_COEF - 1));
          run_d       = '0;
          k_d         = k_q + K_W'(1);
          state_d     = StAcReq;
        end else if (run_q == ZRL_RUN) begin
          req_run_d   = ZRL_RUN;
          req_value_d = '0;
          run_d       = '0;
          k_d         = k_q + K_W'(1);
          state_d     = StAcReq;
        end else begin
          run_d = run_q + 4'd1;
          k_d   = k_q + K_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign blk_ready = (state_q == StIdle);
  assign busy      = ~blk_ready;
  assign enc_req   = (state_q == StDcReq) | (state_q == StAcReq);
  assign enc_is_dc = req_is_dc_q;
  assign enc_ch    = ch_q;
  assign enc_run   = req_run_q;
  assign enc_value = req_value_q;
  assign sym_valid = (state_q == StEmit);
  assign sym_code  = CODE_W'(sym_q.code);
  assign sym_len   = LEN_W'(sym_q.len);
  assign sym_is_dc = sym_q.is_dc;
  assign sym_last  = sym_q.last;
  assign last_xfer = sym_valid & sym_ready & sym_q.last;

`ifdef HUFF_RESTART_EN
  localparam int unsigned CNT_W = (RST_INTERVAL > 1) ? $clog2(RST_INTERVAL) : 1;

  logic [CNT_W-1:0] blk_cnt_q;
  logic             wrap_q, marker_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk_cnt_q <= '0;
      wrap_q    <= 1'b0;
      marker_q  <= 1'b0;
    end else begin
      marker_q <= last_xfer & wrap_q;
      if (accept) wrap_q <= (blk_cnt_q == CNT_W'(RST_INTERVAL - 1)) & ~dc_clear;
      if (dc_clear) begin
        blk_cnt_q <= '0;
      end else if (accept) begin
        blk_cnt_q <= (blk_cnt_q == CNT_W'(RST_INTERVAL - 1)) ? '0 : blk_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rst_marker  = marker_q;
  assign restart_clr = marker_q;
`else
  logic unused_restart;
  assign unused_restart = ^{RST_INTERVAL, last_xfer};
  assign rst_marker     = 1'b0;
  assign restart_clr    = 1'b0;
`endif

endmodule
